mem_access_unit: RTL

MEM-stage access engine sitting downstream of the EX/MEM pipeline register: it consumes the registered EX/MEM fields, runs a req/ack transaction on the data-memory port for loads and stores, and applies byte/half/word lane selection. It stalls the front of the pipeline while a transaction is outstanding and drives the registered MEM/WB outputs consumed by writeback.

---
 rtl/mem_pkg.sv | 40 ++++
 rtl/mem_load_align.sv | 45 ++++
 rtl/mem_access_unit.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants, FSM state type and lane helpers for the MEM-stage access engine
package mem_pkg;

    localparam logic [1:0] TRUNK_WORD = 2'b00;
    localparam logic [1:0] TRUNK_HALF = 2'b01;
    localparam logic [1:0] TRUNK_BYTE = 2'b10;

    typedef logic [1:0] mem_state_t;

    localparam mem_state_t ST_IDLE = 2'd0;
    localparam mem_state_t ST_BUSY = 2'd1;
    localparam mem_state_t ST_DONE = 2'd2;

    // trunk 2'b11 falls through to the word case everywhere
    function automatic logic [3:0] byte_enable(input logic [1:0] trunk, input logic [1:0] offset);
        case (trunk)
            TRUNK_HALF: byte_enable = 4'b0011 << offset;
            TRUNK_BYTE: byte_enable = 4'b0001 << offset;
            default:    byte_enable = 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] trunk, input logic [1:0] offset);
        case (trunk)
            TRUNK_HALF: is_misaligned = offset[0];
            TRUNK_BYTE: is_misaligned = 1'b0;
            default:    is_misaligned = (offset != 2'b00);
        endcase
    endfunction

    // Replicating the low lanes lets byte enables alone pick the target lane
    function automatic logic [31:0] store_data(input logic [1:0] trunk, input logic [31:0] data);
        case (trunk)
            TRUNK_HALF: store_data = {2{data[15:0]}};
            TRUNK_BYTE: store_data = {4{data[7:0]}};
            default:    store_data = data;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - load lane select and extension (macro MEM_SIGN_EXT_EN selects sign extension)
// Ports:
//   rdata_i  [31:0]  raw data-memory read word
//   offset_i [1:0]   byte offset of the access (little-endian lane)
//   trunk_i  [1:0]   access width: word / half / byte (2'b11 = word)
//   data_o   [31:0]  aligned, extended load value
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  trunk_i,
    output logic [31:0] data_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = 8'h00;
        case (offset_i)
            2'd0:    lane_b = rdata_i[7:0];
            2'd1:    lane_b = rdata_i[15:8];
            2'd2:    lane_b = rdata_i[23:16];
            default: lane_b = rdata_i[31:24];
        endcase
    end

    assign lane_h = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        data_o = rdata_i;
        case (trunk_i)
`ifdef MEM_SIGN_EXT_EN
            TRUNK_HALF: data_o = {{16{lane_h[15]}}, lane_h};
            TRUNK_BYTE: data_o = {{24{lane_b[7]}}, lane_b};
`else
            TRUNK_HALF: data_o = {16'h0000, lane_h};
            TRUNK_BYTE: data_o = {24'h000000, lane_b};
`endif
            default:    data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage req/ack data-memory access engine with MEM/WB register (macro MEM_SIGN_EXT_EN)
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   MemRead_MEM/MemWrite_MEM        access request from EX/MEM (both set = store)
//   trunkMode_MEM [1:0]             00 word, 01 half, 10 byte, 11 word
//   ALU_result_MEM/Read_Data_2_MEM  address / store data
//   RegWrite_MEM/MemToReg_MEM/Write_register_MEM  writeback controls
//   dmem_*                          data-memory req/ack port
//   stall                           freezes front of pipeline (combinational)
//   *_WB                            registered MEM/WB outputs
//   misaligned                      one-cycle pulse; bus_error sticky until reset
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead_MEM,
    input  logic        MemWrite_MEM,
    input  logic [1:0]  trunkMode_MEM,
    input  logic [31:0] ALU_result_MEM,
    input  logic [31:0] Read_Data_2_MEM,
    input  logic        RegWrite_MEM,
    input  logic        MemToReg_MEM,
    input  logic [4:0]  Write_register_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic [31:0] Read_data_WB,
    output logic [31:0] ALU_result_WB,
    output logic        RegWrite_WB,
    output logic        MemToReg_WB,
    output logic [4:0]  Write_register_WB,
    output logic        misaligned,
    output logic        bus_error
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       ldata_q, ldata_d;
    logic              tmo_q, tmo_d;
    logic              mis_q, mis_d;
    logic              berr_q, berr_d;
    logic [31:0]       wb_rdata_q, wb_rdata_d;
    logic [31:0]       wb_alu_q, wb_alu_d;
    logic              wb_rw_q, wb_rw_d;
    logic              wb_m2r_q, wb_m2r_d;
    logic [4:0]        wb_wreg_q, wb_wreg_d;

    logic              access;
    logic              access_mis;
    logic              start;
    logic [31:0]       load_aligned;

    assign access     = MemRead_MEM | MemWrite_MEM;
    assign access_mis = access & is_misaligned(trunkMode_MEM, ALU_result_MEM[1:0]);
    assign start      = (state_q == ST_IDLE) & access & ~access_mis;

    // EX/MEM is frozen during BUSY, so the live address offset and trunk
    // still describe the outstanding access when the ack arrives.
    mem_load_align u_load_align (
        .rdata_i  (dmem_rdata),
        .offset_i (ALU_result_MEM[1:0]),
        .trunk_i  (trunkMode_MEM),
        .data_o   (load_aligned)
    );

    assign stall = start | (state_q == ST_BUSY);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        ldata_d    = ldata_q;
        tmo_d      = tmo_q;
        mis_d      = 1'b0;
        berr_d     = berr_q;
        wb_rdata_d = wb_rdata_q;
        wb_alu_d   = wb_alu_q;
        wb_rw_d    = wb_rw_q;
        wb_m2r_d   = wb_m2r_q;
        wb_wreg_d  = wb_wreg_q;

        case (state_q)
            ST_IDLE: begin
                wb_rdata_d = 32'h0;
                if (start) begin
                    state_d   = ST_BUSY;
                    cnt_d     = '0;
                    req_d     = 1'b1;
                    we_d      = MemWrite_MEM;
                    addr_d    = {ALU_result_MEM[31:2], 2'b00};
                    be_d      = byte_enable(trunkMode_MEM, ALU_result_MEM[1:0]);
                    wdata_d   = store_data(trunkMode_MEM, Read_Data_2_MEM);
                    ldata_d   = 32'h0;
                    tmo_d     = 1'b0;
                    // the instruction retires from DONE; this slot is a bubble
                    wb_alu_d  = 32'h0;
                    wb_rw_d   = 1'b0;
                    wb_m2r_d  = 1'b0;
                    wb_wreg_d = 5'd0;
                end else if (access_mis) begin
                    mis_d     = 1'b1;
                    wb_alu_d  = 32'h0;
                    wb_rw_d   = 1'b0;
                    wb_m2r_d  = 1'b0;
                    wb_wreg_d = 5'd0;
                end else begin
                    wb_alu_d  = ALU_result_MEM;
                    wb_rw_d   = RegWrite_MEM;
                    wb_m2r_d  = MemToReg_MEM;
                    wb_wreg_d = Write_register_MEM;
                end
            end
            ST_BUSY: begin
                // an ack on the final counted cycle still wins over the timeout
                if (dmem_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                    if (!we_q) begin
                        ldata_d = load_aligned;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    berr_d  = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                wb_rdata_d = ldata_q;
                wb_alu_d   = ALU_result_MEM;
                wb_rw_d    = RegWrite_MEM & ~tmo_q;
                wb_m2r_d   = MemToReg_MEM;
                wb_wreg_d  = Write_register_MEM;
                cnt_d      = '0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            be_q       <= 4'h0;
            ldata_q    <= 32'h0;
            tmo_q      <= 1'b0;
            mis_q      <= 1'b0;
            berr_q     <= 1'b0;
            wb_rdata_q <= 32'h0;
            wb_alu_q   <= 32'h0;
            wb_rw_q    <= 1'b0;
            wb_m2r_q   <= 1'b0;
            wb_wreg_q  <= 5'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            ldata_q    <= ldata_d;
            tmo_q      <= tmo_d;
            mis_q      <= mis_d;
            berr_q     <= berr_d;
            wb_rdata_q <= wb_rdata_d;
            wb_alu_q   <= wb_alu_d;
            wb_rw_q    <= wb_rw_d;
            wb_m2r_q   <= wb_m2r_d;
            wb_wreg_q  <= wb_wreg_d;
        end
    end

    assign dmem_req          = req_q;
    assign dmem_we           = we_q;
    assign dmem_addr         = addr_q;
    assign dmem_wdata        = wdata_q;
    assign dmem_be           = be_q;
    assign Read_data_WB      = wb_rdata_q;
    assign ALU_result_WB     = wb_alu_q;
    assign RegWrite_WB       = wb_rw_q;
    assign MemToReg_WB       = wb_m2r_q;
    assign Write_register_WB = wb_wreg_q;
    assign misaligned        = mis_q;
    assign bus_error         = berr_q;

endmodule
